// File: rtl/konw_pkg.sv
// Shared types for the konwersja_pipe number-format converter.
package konw_pkg;

   typedef enum logic [1:0] {
      MODE_ZM2U2  = 2'b00,
      MODE_U22ZM  = 2'b01,
      MODE_U22OFF = 2'b10,
      MODE_OFF2U2 = 2'b11
   } conv_mode_t;

   typedef struct packed {
      logic ovf;
      logic negzero;
   } konw_flags_t;

endpackage

// File: rtl/konwersja_pipe_if.sv
// Valid/ready bus of konwersja_pipe: operand side towards the operand mux, result side towards the ALU path.
interface konwersja_pipe_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_argA;
   logic [1:0]       i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_ovf;
   logic             o_negzero;
   logic [CNT_W-1:0] o_count;

   modport slave (
      input  i_valid, i_argA, i_mode, i_ready,
      output o_ready, o_valid, o_result, o_ovf, o_negzero, o_count
   );

   modport master (
      output i_valid, i_argA, i_mode, i_ready,
      input  o_ready, o_valid, o_result, o_ovf, o_negzero, o_count
   );
endinterface

// File: rtl/konw_core.sv
// Combinational ZM / U2 / offset-binary conversion with overflow and negative-zero flags.
// KONW_SAT_EN: when defined, U2->ZM of the most-negative value saturates to 1 followed by all ones.
module konw_core
   import konw_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] arg,
   input  conv_mode_t       mode,
   output logic [WIDTH-1:0] result,
   output konw_flags_t      flags
);

`ifdef KONW_SAT_EN
   localparam logic [WIDTH-1:0] OVF_RESULT = {WIDTH{1'b1}};
`else
   localparam logic [WIDTH-1:0] OVF_RESULT = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic             sign;
   logic             low_zero;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] neg_mag;
   logic [WIDTH-1:0] neg_arg;

   assign sign     = arg[WIDTH-1];
   assign low_zero = (arg[WIDTH-2:0] == '0);
   assign mag      = {1'b0, arg[WIDTH-2:0]};
   assign neg_mag  = -mag;
   assign neg_arg  = -arg;

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      result = arg;
      flags  = '0;
      unique case (mode)
         MODE_ZM2U2: begin
            if (sign) begin
               result        = neg_mag;
               flags.negzero = low_zero;
            end
         end
         MODE_U22ZM: begin
            if (sign) begin
               if (low_zero) begin
                  result    = OVF_RESULT;
                  flags.ovf = 1'b1;
               end else begin
                  result = {1'b1, neg_arg[WIDTH-2:0]};
               end
            end
         end
         MODE_U22OFF,
         MODE_OFF2U2: result = {~arg[WIDTH-1], arg[WIDTH-2:0]};
         default:     result = arg;
      endcase
   end

endmodule

// File: rtl/konwersja_pipe.sv
// Two-stage valid/ready number-format converter with flags and an accepted-transaction counter.
// Optional macro KONW_SAT_EN (see konw_core) selects the saturating U2->ZM overflow result.
module konwersja_pipe
   import konw_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic             i_clk,
   input logic             i_rst,
   konwersja_pipe_if.slave bus
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_arg;
   conv_mode_t       s1_mode;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   konw_flags_t      s2_flags;

   logic [CNT_W-1:0] count;

   logic             s1_load;
   logic             s2_load;
   logic             accept;

   logic [WIDTH-1:0] core_result;
   konw_flags_t      core_flags;

   // Ready ripples back from the consumer in the same cycle to keep full throughput.
   assign s2_load = !s2_valid || bus.i_ready;
   assign s1_load = !s1_valid || s2_load;
   assign accept  = bus.i_valid && s1_load;

   konw_core #(.WIDTH(WIDTH)) u_core (
      .arg    (s1_arg),
      .mode   (s1_mode),
      .result (core_result),
      .flags  (core_flags)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
         count     <= '0;
      end else begin
         if (s1_load) s1_valid <= accept;
         if (s2_load) s2_valid <= s1_valid;
         if (s2_load && s1_valid) begin
            s2_result <= core_result;
            s2_flags  <= core_flags;
         end
         if (accept) count <= count + 1'b1;
      end
   end

   // NOTE: stage-1 payload has no reset; it is only observed behind s1_valid.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         s1_arg  <= bus.i_argA;
         s1_mode <= conv_mode_t'(bus.i_mode);
      end
   end

   assign bus.o_ready   = s1_load;
   assign bus.o_valid   = s2_valid;
   assign bus.o_result  = s2_result;
   assign bus.o_ovf     = s2_flags.ovf;
   assign bus.o_negzero = s2_flags.negzero;
   assign bus.o_count   = count;

endmodule

// File: tb/tb_konwersja_pipe.sv
// Bench for konwersja_pipe: an 8-bit/4-bit-counter instance and a 32-bit instance behind one stimulus set.
module tb_konwersja_pipe;
   import konw_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        nz;
      int          cyc;
      bit          stalled;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        sel;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_argA;
   logic [1:0]  i_mode;

   logic        o_ready, o_valid, o_ovf, o_negzero;
   logic [31:0] o_result;
   logic [15:0] o_count;

   exp_t        q[$];
   logic [31:0] outs[$];
   logic [31:0] last_out;
   logic        last_ovf, last_nz;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          cnt[2];
   bit          saw_notready;
   bit          rand_rdy;
   bit          held_v;
   logic [31:0] held_r;
   logic [1:0]  held_f;

   konwersja_pipe_if #(.WIDTH(8),  .CNT_W(4))  b8 ();
   konwersja_pipe_if #(.WIDTH(32), .CNT_W(16)) b32 ();

   assign b8.i_valid  = i_valid & ~sel;
   assign b8.i_argA   = i_argA[7:0];
   assign b8.i_mode   = i_mode;
   assign b8.i_ready  = i_ready;
   assign b32.i_valid = i_valid & sel;
   assign b32.i_argA  = i_argA;
   assign b32.i_mode  = i_mode;
   assign b32.i_ready = i_ready;

   assign o_ready   = sel ? b32.o_ready   : b8.o_ready;
   assign o_valid   = sel ? b32.o_valid   : b8.o_valid;
   assign o_ovf     = sel ? b32.o_ovf     : b8.o_ovf;
   assign o_negzero = sel ? b32.o_negzero : b8.o_negzero;
   assign o_result  = sel ? b32.o_result  : {24'h0, b8.o_result};
   assign o_count   = sel ? b32.o_count   : {12'h0, b8.o_count};

   konwersja_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (b8)
   );

   konwersja_pipe #(.WIDTH(32), .CNT_W(16)) dut32 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (b32)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference conversion on integer values of an n-bit word.
   function automatic exp_t model(input logic [31:0] a_in, input int n, input logic [1:0] mode);
      longint full, half, a, v, mag;
      exp_t   e;
      full      = longint'(1) << n;
      half      = full / 2;
      a         = longint'(a_in) & (full - 1);
      e.ovf     = 1'b0;
      e.nz      = 1'b0;
      e.cyc     = 0;
      e.stalled = 1'b0;
      case (mode)
         2'b00: begin
            mag   = a % half;
            v     = (a >= half) ? -mag : mag;
            e.nz  = (a == half);
            e.res = 32'((v + full) % full);
         end
         2'b01: begin
            v = (a >= half) ? a - full : a;
            if (v == -half) begin
               e.ovf = 1'b1;
`ifdef KONW_SAT_EN
               e.res = 32'(full - 1);
`else
               e.res = 32'(a);
`endif
            end else if (v < 0) begin
               e.res = 32'(half - v);
            end else begin
               e.res = 32'(v);
            end
         end
         2'b10:   e.res = 32'((a + half) % full);
         default: e.res = 32'((a + full - half) % full);
      endcase
      return e;
   endfunction

   // Scoreboard: inputs and outputs sampled mid-cycle, away from the active edge.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         q.delete();
         held_v = 1'b0;
         cnt[0] = 0;
         cnt[1] = 0;
      end else begin
         check("count", 64'(o_count), 64'(cnt[sel]));
         if (held_v && o_valid) begin
            check("hold_result", 64'(o_result), 64'(held_r));
            check("hold_flags", 64'({o_ovf, o_negzero}), 64'(held_f));
         end
         if (!o_ready) saw_notready = 1'b1;
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(o_valid), 64'(0));
            end else begin
               e = q.pop_front();
               check("result", 64'(o_result), 64'(e.res));
               check("ovf", 64'(o_ovf), 64'(e.ovf));
               check("negzero", 64'(o_negzero), 64'(e.nz));
               if (!e.stalled) check("latency", 64'(cyc - e.cyc), 64'(2));
               last_out = o_result;
               last_ovf = o_ovf;
               last_nz  = o_negzero;
               outs.push_back(o_result);
            end
         end
         held_v = o_valid && !i_ready;
         held_r = o_result;
         held_f = {o_ovf, o_negzero};
         if (!i_ready) foreach (q[i]) q[i].stalled = 1'b1;
         if (i_valid && o_ready) begin
            e     = model(i_argA, sel ? 32 : 8, i_mode);
            e.cyc = cyc;
            q.push_back(e);
            cnt[sel] = (cnt[sel] + 1) % (sel ? 65536 : 16);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [1:0] m);
      bit done = 1'b0;
      i_valid = 1'b1;
      i_argA  = a;
      i_mode  = m;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge i_clk);
         if (o_ready) done = 1'b1;
      end
      if (!done) check("send_timeout", 64'(o_ready), 64'(1));
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge i_clk);
         #2;
         if (q.size() == 0 && !o_valid) done = 1'b1;
      end
      if (!done) check("drain_timeout", 64'(q.size()) + 64'(o_valid), 64'(0));
   endtask

   initial begin
      logic [31:0] corners[6];
      logic [31:0] a;
      logic [31:0] x;
      corners = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1};
      i_rst = 1'b1; sel = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_argA = '0; i_mode = '0; rand_rdy = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_ready", 64'(o_ready), 64'(1));
      check("rst_count", 64'(o_count), 64'(0));
      check("rst_result", 64'(o_result), 64'(0));
      @(posedge i_clk);
      #1;

      // Four modes back to back on the 8-bit instance.
      outs.delete();
      send(32'h85, MODE_ZM2U2);
      send(32'hFB, MODE_U22ZM);
      send(32'hFB, MODE_U22OFF);
      send(32'h7B, MODE_OFF2U2);
      drain();
      check("t1_n", 64'(outs.size()), 64'(4));
      check("t1_0", 64'(outs[0]), 64'h FB);
      check("t1_1", 64'(outs[1]), 64'h 85);
      check("t1_2", 64'(outs[2]), 64'h 7B);
      check("t1_3", 64'(outs[3]), 64'h FB);
      check("t1_count", 64'(o_count), 64'(4));

      // Most-negative U2 to ZM.
      send(32'h80, MODE_U22ZM);
      drain();
`ifdef KONW_SAT_EN
      check("ovf_result", 64'(last_out), 64'h FF);
`else
      check("ovf_result", 64'(last_out), 64'h 80);
`endif
      check("ovf_flag", 64'(last_ovf), 64'(1));

      // ZM negative zero.
      send(32'h80, MODE_ZM2U2);
      drain();
      check("nz_result", 64'(last_out), 64'(0));
      check("nz_flag", 64'(last_nz), 64'(1));
      check("nz_ovf", 64'(last_ovf), 64'(0));

      // Backpressure while streaming.
      saw_notready = 1'b0;
      outs.delete();
      fork
         for (int k = 1; k <= 5; k++) send(32'(k), MODE_ZM2U2);
         begin
            repeat (3) @(posedge i_clk);
            #1 i_ready = 1'b0;
            repeat (4) @(posedge i_clk);
            #1 i_ready = 1'b1;
         end
      join
      drain();
      check("bp_ready_drop", 64'(saw_notready), 64'(1));
      check("bp_n", 64'(outs.size()), 64'(5));
      for (int k = 0; k < 5; k++) check("bp_order", 64'(outs[k]), 64'(k + 1));

      // Reset with two transactions in flight.
      outs.delete();
      i_ready = 1'b0;
      send(32'h11, MODE_ZM2U2);
      send(32'h22, MODE_ZM2U2);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst2_valid", 64'(o_valid), 64'(0));
      check("rst2_count", 64'(o_count), 64'(0));
      check("rst2_ready", 64'(o_ready), 64'(1));
      @(posedge i_clk);
      #1 i_ready = 1'b1;
      repeat (6) @(posedge i_clk);
      #1;
      check("rst2_no_out", 64'(outs.size()), 64'(0));

      // 4-bit counter wraps after 16 accepts.
      for (int k = 0; k < 17; k++) send($urandom, 2'($urandom_range(0, 3)));
      drain();
      check("cnt_wrap", 64'(o_count), 64'(1));

      // Random traffic on the 32-bit instance with random downstream stalls.
      sel = 1'b1;
      @(posedge i_clk);
      #1;
      rand_rdy = 1'b1;
      fork
         while (rand_rdy) begin
            @(posedge i_clk);
            #1 i_ready = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int k = 0; k < 200; k++) begin
         a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 4) == 0) begin
            @(posedge i_clk);
            #1;
         end
         send(a, 2'($urandom_range(0, 3)));
      end
      rand_rdy = 1'b0;
      @(posedge i_clk);
      #2 i_ready = 1'b1;
      drain();

      // ZM -> U2 -> ZM round trip returns the operand.
      for (int k = 0; k < 8; k++) begin
         x = $urandom;
         if (x == 32'h8000_0000) x = 32'h8000_0001;
         send(x, MODE_ZM2U2);
         drain();
         send(last_out, MODE_U22ZM);
         drain();
         check("round_trip", 64'(last_out), 64'(x));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
